// File: rtl/io_input_reg_pkg.sv
// Shared IO address map and defaults for the CPU-facing input and output port registers.
package io_input_reg_pkg;

    localparam int DATA_W              = 32;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Word addresses, i.e. addr[7:2]
    localparam logic [5:0] ADDR_IN0    = 6'b110000;
    localparam logic [5:0] ADDR_IN1    = 6'b110001;
    localparam logic [5:0] ADDR_STATUS = 6'b110010;
    localparam logic [5:0] ADDR_OUT0   = 6'b100000;
    localparam logic [5:0] ADDR_OUT1   = 6'b100001;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IN0,
        SEL_IN1,
        SEL_STATUS
    } rd_sel_e;

    function automatic rd_sel_e decode_sel(input logic [5:0] word_addr);
        rd_sel_e sel;
        case (word_addr)
            ADDR_IN0:    sel = SEL_IN0;
            ADDR_IN1:    sel = SEL_IN1;
            ADDR_STATUS: sel = SEL_STATUS;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/io_input_reg_if.sv
// CPU read bus for the input-port register block.
interface io_input_reg_if;
    import io_input_reg_pkg::*;

    logic [31:0]       addr;
    logic              read_io_enable;
    logic [DATA_W-1:0] dataout;

    modport master (output addr, output read_io_enable, input dataout);
    modport slave  (input addr, input read_io_enable, output dataout);

endinterface

// File: rtl/io_input_debounce.sv
// One input port: 2-flop synchronizer, stable-count debouncer and sticky change flag.
module io_input_debounce
    import io_input_reg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] deb,
    output logic              chg
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] s1, s2, cand;
    logic [7:0]        cnt;
    logic              stable, qualify, set_chg;

    assign stable  = (s2 == cand);
    assign qualify = stable && (cnt == CNT_LAST);
    assign set_chg = qualify && (deb != cand);

    always_ff @(posedge io_clk) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
            chg  <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (!stable) begin
                cand <= s2;
                cnt  <= '0;
            end else if (!qualify) begin
                cnt <= cnt + 8'd1;
            end
            if (qualify) deb <= cand;
            // A new change event beats a same-edge clear so no event is lost.
            if (set_chg)  chg <= 1'b1;
            else if (clr) chg <= 1'b0;
        end
    end

endmodule

// File: rtl/io_input_reg.sv
// Input-port register block: two debounced ports, status flags and clear-on-read decode.
module io_input_reg
    import io_input_reg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_port0,
    input  logic [DATA_W-1:0] in_port1,
    io_input_reg_if.slave     bus
);

    rd_sel_e           sel;
    logic              clr0, clr1;
    logic              chg0, chg1;
    logic [DATA_W-1:0] deb0, deb1;
    logic              unused_addr;

    assign sel         = decode_sel(bus.addr[7:2]);
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};
    assign clr0        = bus.read_io_enable && (sel == SEL_IN0);
    assign clr1        = bus.read_io_enable && (sel == SEL_IN1);

    io_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port0 (
        .io_clk (io_clk),
        .reset  (reset),
        .din    (in_port0),
        .clr    (clr0),
        .deb    (deb0),
        .chg    (chg0)
    );

    io_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port1 (
        .io_clk (io_clk),
        .reset  (reset),
        .din    (in_port1),
        .clr    (clr1),
        .deb    (deb1),
        .chg    (chg1)
    );

    always_comb begin
        bus.dataout = '0;
        case (sel)
            SEL_IN0:    bus.dataout = deb0;
            SEL_IN1:    bus.dataout = deb1;
            SEL_STATUS: bus.dataout = {30'b0, chg1, chg0};
            default:    bus.dataout = '0;
        endcase
    end

endmodule

// File: tb/tb_io_input_reg.sv
// Bench for io_input_reg: directed latency/clear/reset sequences, a read-vector table and random traffic.
module tb_io_input_reg;

    localparam int D = 4;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [31:0] in_port0, in_port1;

    io_input_reg_if bus();

    io_input_reg #(.DEBOUNCE_CYCLES(D)) dut (
        .io_clk   (io_clk),
        .reset    (reset),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .bus      (bus)
    );

    always #5 io_clk = ~io_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: per port, the synchronizer delay line plus the length of the
    // current run of identical synchronized samples.
    logic [31:0] m_s1[2], m_s2[2], m_run_val[2], m_deb[2];
    int          m_run_len[2];
    logic        m_chg[2];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[7:2])
            6'b110000: return m_deb[0];
            6'b110001: return m_deb[1];
            6'b110010: return {30'b0, m_chg[1], m_chg[0]};
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [31:0] in0, input logic [31:0] in1,
                              input logic [31:0] a, input logic rd);
        logic [31:0] inp[2];
        logic [31:0] samp;
        logic        set;
        inp[0] = in0;
        inp[1] = in1;
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                m_s1[p] = 0; m_s2[p] = 0; m_run_val[p] = 0; m_run_len[p] = 1;
                m_deb[p] = 0; m_chg[p] = 1'b0;
            end else begin
                samp    = m_s2[p];
                m_s2[p] = m_s1[p];
                m_s1[p] = inp[p];
                if (samp == m_run_val[p]) begin
                    if (m_run_len[p] < 1000) m_run_len[p]++;
                end else begin
                    m_run_val[p] = samp;
                    m_run_len[p] = 1;
                end
                set = 1'b0;
                if (m_run_len[p] >= D + 1) begin
                    set      = (m_deb[p] != m_run_val[p]);
                    m_deb[p] = m_run_val[p];
                end
                if (set) m_chg[p] = 1'b1;
                else if (rd && a[7:2] == 6'(48 + p)) m_chg[p] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input logic rst, input logic [31:0] in0, input logic [31:0] in1,
                        input logic [31:0] a, input logic rd);
        reset              = rst;
        in_port0           = in0;
        in_port1           = in1;
        bus.addr           = a;
        bus.read_io_enable = rd;
        @(posedge io_clk);
        model_edge(rst, in0, in1, a, rd);
        #1;
        check("model", bus.dataout, m_read(a));
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.addr           = a;
        bus.read_io_enable = 1'b0;
        #1;
        check(name, bus.dataout, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] exp_data;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [31:0] r0, r1, ra, pool[4];

        vecs[0] = '{32'h0C8, 1'b1, 32'h1,  32'h1};
        vecs[1] = '{32'h0CC, 1'b1, 32'h0,  32'h1};
        vecs[2] = '{32'h080, 1'b1, 32'h0,  32'h1};
        vecs[3] = '{32'h000, 1'b0, 32'h0,  32'h1};
        vecs[4] = '{32'h0C0, 1'b0, 32'h5A, 32'h1};
        vecs[5] = '{32'h1C0, 1'b1, 32'h5A, 32'h0};
        vecs[6] = '{32'h0C5, 1'b0, 32'h0,  32'h0};
        vecs[7] = '{32'h0C8, 1'b1, 32'h0,  32'h0};

        // Reset state
        tick(1'b1, 32'h0, 32'h0, 32'h0C0, 1'b0);
        tick(1'b1, 32'h0, 32'h0, 32'h0C0, 1'b0);
        peek(32'h0C0, 32'h0, "rst_deb0");
        peek(32'h0C4, 32'h0, "rst_deb1");
        peek(32'h0C8, 32'h0, "rst_status");

        // Qualification latency
        for (int e = 1; e <= 7; e++) begin
            tick(1'b0, 32'hA5, 32'h0, 32'h0C0, 1'b0);
            check($sformatf("latency_e%0d", e), bus.dataout, (e < 7) ? 32'h0 : 32'hA5);
        end
        peek(32'h0C8, 32'h1, "status_after_qual");

        // Unmapped reads have no side effects
        tick(1'b0, 32'hA5, 32'h0, 32'h0CC, 1'b1);
        check("unmapped_0cc", bus.dataout, 32'h0);
        tick(1'b0, 32'hA5, 32'h0, 32'h080, 1'b1);
        check("unmapped_080", bus.dataout, 32'h0);
        peek(32'h0C8, 32'h1, "status_after_unmapped");

        // Status read does not clear; port read does
        tick(1'b0, 32'hA5, 32'h0, 32'h0C8, 1'b1);
        check("status_read", bus.dataout, 32'h1);
        tick(1'b0, 32'hA5, 32'h0, 32'h0C0, 1'b1);
        check("port0_read", bus.dataout, 32'hA5);
        peek(32'h0C8, 32'h0, "status_after_clear");

        // Short glitch on port 1 is filtered
        for (int i = 0; i < 3; i++) tick(1'b0, 32'hA5, 32'hFFFF_0000, 32'h0C4, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 32'hA5, 32'h0, 32'h0C4, 1'b0);
        peek(32'h0C4, 32'h0, "glitch_deb1");
        peek(32'h0C8, 32'h0, "glitch_status");

        // Clear-on-read coinciding with a new change event
        for (int e = 1; e <= 6; e++) tick(1'b0, 32'h5A, 32'h0, 32'h0C0, 1'b0);
        check("before_update", bus.dataout, 32'hA5);
        tick(1'b0, 32'h5A, 32'h0, 32'h0C0, 1'b1);
        check("update_with_clear", bus.dataout, 32'h5A);
        peek(32'h0C8, 32'h1, "set_wins");

        // Read-vector table
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h5A, 32'h0, vecs[i].addr, vecs[i].rd);
            check($sformatf("vec%0d_data", i), bus.dataout, vecs[i].exp_data);
            peek(32'h0C8, vecs[i].exp_status, $sformatf("vec%0d_status", i));
        end

        // Reset one edge before port 1 would qualify
        for (int e = 1; e <= 5; e++) tick(1'b0, 32'h5A, 32'h1234_5678, 32'h0C4, 1'b0);
        tick(1'b1, 32'h5A, 32'h1234_5678, 32'h0C4, 1'b1);
        check("midreset_deb1", bus.dataout, 32'h0);
        peek(32'h0C0, 32'h0, "midreset_deb0");
        peek(32'h0C8, 32'h0, "midreset_status");
        for (int e = 1; e <= 7; e++) begin
            tick(1'b0, 32'h5A, 32'h1234_5678, 32'h0C4, 1'b0);
            check($sformatf("requal_e%0d", e), bus.dataout, (e < 7) ? 32'h0 : 32'h1234_5678);
        end

        // Random traffic against the reference
        pool[0] = 32'h0;
        pool[1] = 32'hFFFF_FFFF;
        pool[2] = 32'hA5A5_5A5A;
        pool[3] = 32'h0000_0001;
        r0 = 32'h5A;
        r1 = 32'h1234_5678;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) r0 = $urandom_range(0, 1) ? $urandom : pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) r1 = $urandom_range(0, 1) ? $urandom : pool[$urandom_range(0, 3)];
            case ($urandom_range(0, 5))
                0:       ra = 32'h0C0;
                1:       ra = 32'h0C4;
                2:       ra = 32'h0C8;
                3:       ra = 32'h0CC;
                4:       ra = {$urandom_range(0, 65535), 8'hC0 | 8'($urandom_range(0, 11))};
                default: ra = $urandom;
            endcase
            tick($urandom_range(0, 99) == 0, r0, r1, ra, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
